ray_march_engine: RTL and testbench
===================================

// Module: ray_march_engine
// PURPOSE
//  Parametrised sphere-tracing engine: next generation of the single-ray marcher.
//  Accepts one ray per ready/valid transaction and iterates p = ro + t*rd, t += sdf(p).
//  Runs until hit, miss (t > MAX_DIST) or the step budget is exhausted.
//  Returns hit, t, p, step count and a caller tag. Sits between the camera ray generator and the shader.
// PARAMETERS
//  MAX_STEPS  64                       max SDF evaluations per ray (>=1)
//  HIT_EPS    32'sd16777               hit threshold, Q8.24 (~0.001)
//  MAX_DIST   32'sh1000_0000           far plane, Q8.24 (16.0)
//  SDF_LAT    4                        fixed latency of sdf_scene, cycles (>=1)
//  OBJ_W      2                        object-select width
//  TAG_W      4                        ray tag width
//  STEP_W     $clog2(MAX_STEPS+1)      step counter width
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       ray request valid
//  in_ready   out  1       engine idle, can accept a ray
//  ray_origin in   vec3    ray origin, Q8.24 per component
//  ray_dir    in   vec3    unit direction, Q8.24
//  obj_sel    in   OBJ_W   scene select: 0 = unit sphere at origin, 1 = plane y=0, others = sphere
//  in_tag     in   TAG_W   caller tag, returned unchanged
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  hit        out  1       1 = surface reached
//  distance   out  fp      final t, Q8.24
//  point      out  vec3    final sample point ro + t*rd
//  steps      out  STEP_W  number of SDF evaluations performed
//  out_tag    out  TAG_W   tag of the ray being reported
// BEHAVIOUR
//  Reset: state = IDLE. in_ready=1, out_valid=0. hit, distance, point, steps, out_tag all 0.
//  Input handshake:
//   - Accept when in_valid && in_ready.
//   - Latch ro, rd, obj_sel and tag; set t=0, steps=0; go to EVAL.
//   - in_ready=1 only in IDLE.
//  FSM:
//   - IDLE: wait for an accepted ray.
//   - EVAL: compute p = ro + t*rd; launch sdf_scene; wait exactly SDF_LAT cycles; steps += 1; go to CHECK.
//   - CHECK, evaluated in this order:
//     1. d < HIT_EPS                  -> hit=1, DONE.
//     2. t+d > MAX_DIST               -> hit=0, DONE. distance = t+d, point = p at the last evaluated t.
//     3. steps == MAX_STEPS           -> hit=0, DONE.
//     4. otherwise                    -> t = t+d, back to EVAL.
//   - DONE: out_valid=1; outputs held stable until out_ready; then IDLE.
//     out_valid && out_ready with in_valid in the same cycle: ray accepted next cycle (no bypass).
//  Latency (unstalled): accept -> out_valid = steps*(SDF_LAT+2)+1 cycles.
//  Arithmetic (Q8.24 signed 32-bit):
//   - Multiply: 64-bit product, arithmetic >>>24, saturate to +/-max.
//   - Add: saturating.
//   - t never wraps; a negative d (point inside surface) counts as a hit.
//  Reset mid-ray: on the next edge, return to IDLE and drop the ray; out_valid stays 0.
//  in_valid while busy is ignored; the source must hold its data until the handshake.
// STRUCTURE
//  vector_pkg:
//   - Types fp, vec3.
//   - Constants FP_FRAC=24, FP_ONE.
//   - Functions make_vec3, fp_mul_sat, fp_add_sat, vec3_add, vec3_scale.
//  Sub-module sdf_scene:
//   - Pipelined signed distance, latency SDF_LAT.
//   - Includes an iterative/pipelined sqrt for length().
//   - Ports: clk, rst, p, obj_sel, valid_in -> d, valid_out.
//  Engine owns the FSM, t/step registers, point arithmetic and the output register.
// TESTING (defaults unless stated; distances to +/-2^-16)
//  1. Sphere hit: ro=(0,0,3), rd=(0,0,-1), sel=0, tag=5
//     -> hit=1, distance=2.0, point=(0,0,1), steps=2, out_tag=5.
//  2. Plane hit: ro=(0,5,0), rd=(0,-1,0), sel=1
//     -> hit=1, distance=5.0, point=(0,0,0), steps=2.
//  3. Far-plane miss: ro=(0,0,3), rd=(0,1,0), sel=0
//     -> hit=0, steps=4, distance~17.6 (>16).
//  4. Step budget: case 3 with MAX_STEPS=2 -> hit=0, steps=2, distance~4.606.
//  5. Backpressure: hold out_ready=0 for 10 cycles after out_valid
//     -> outputs stable, in_ready=0; one out_ready pulse -> in_ready=1 next cycle.
//  6. Reset during EVAL of case 1
//     -> no out_valid; in_ready=1 after reset; case 2 then completes correctly.

Source files
------------

// File: rtl/vector_pkg.sv
// Q8.24 fixed-point vector types and saturating helpers shared by the
// ray-march engine and its scene SDF. Also holds the engine state encoding.
package vector_pkg;
  localparam int FP_FRAC = 24;

  typedef logic signed [31:0] fp;
  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp FP_ONE = 32'sh0100_0000;
  localparam fp FP_MAX = 32'sh7fff_ffff;
  localparam fp FP_MIN = 32'sh8000_0000;

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_WAIT, S_CHECK, S_DONE} march_state_t;

  function automatic vec3 make_vec3(fp x, fp y, fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  // Full 64-bit product, rescale, clamp into the 32-bit range.
  function automatic fp fp_mul_sat(fp a, fp b);
    logic signed [63:0] ae, be, pr;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    pr = (ae * be) >>> FP_FRAC;
    if (pr > 64'sh0000_0000_7fff_ffff) return FP_MAX;
    if (pr < 64'shffff_ffff_8000_0000) return FP_MIN;
    return pr[31:0];
  endfunction

  function automatic fp fp_add_sat(fp a, fp b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? FP_MIN : FP_MAX;
    return s[31:0];
  endfunction

  function automatic vec3 vec3_add(vec3 a, vec3 b);
    return make_vec3(fp_add_sat(a.x, b.x), fp_add_sat(a.y, b.y), fp_add_sat(a.z, b.z));
  endfunction

  function automatic vec3 vec3_scale(vec3 v, fp s);
    return make_vec3(fp_mul_sat(v.x, s), fp_mul_sat(v.y, s), fp_mul_sat(v.z, s));
  endfunction

  // Exact square of a Q8.24 value as an unsigned Q16.48 magnitude.
  function automatic logic [63:0] fp_sqr(fp a);
    logic signed [63:0] e;
    e = {{32{a[31]}}, a};
    return e * e;
  endfunction
endpackage

// File: rtl/sdf_scene.sv
// Scene signed-distance evaluator with fixed latency SDF_LAT.
//  p, obj_sel, valid_in : sample point (Q8.24 vec3), scene select, launch strobe
//  d, valid_out         : signed distance (Q8.24), asserted SDF_LAT cycles after launch
// obj_sel 1 is the plane y=0; every other select is the unit sphere at origin.
module sdf_scene
  import vector_pkg::*;
#(
  parameter int SDF_LAT = 4,
  parameter int OBJ_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [95:0]       p,
  input  logic [OBJ_W-1:0]  obj_sel,
  input  logic              valid_in,
  output logic [31:0]       d,
  output logic              valid_out
);
  // Unrolled digit-by-digit square root: floor(sqrt(v)). A Q16.48 radicand
  // yields a Q8.24 root directly.
  function automatic logic [31:0] isqrt64(logic [63:0] v);
    logic [63:0] rem, res, bit_q;
    rem   = v;
    res   = '0;
    bit_q = 64'h4000_0000_0000_0000;
    for (int i = 0; i < 32; i++) begin
      if (rem >= res + bit_q) begin
        rem = rem - (res + bit_q);
        res = (res >> 1) + bit_q;
      end else begin
        res = res >> 1;
      end
      bit_q = bit_q >> 2;
    end
    return res[31:0];
  endfunction

  vec3                 pv;
  logic [63:0]         len2;
  logic [31:0]         len;
  logic signed [33:0]  dl;
  fp                   d_now;

  logic [SDF_LAT-1:0][31:0] d_pipe;
  logic [SDF_LAT-1:0]       vld_pipe;

  assign pv = p;

  always_comb begin
    len2  = fp_sqr(pv.x) + fp_sqr(pv.y) + fp_sqr(pv.z);
    len   = isqrt64(len2);
    dl    = $signed({2'b00, len}) - 34'sd16777216;
    d_now = FP_MAX;
    if (obj_sel == OBJ_W'(1))           d_now = pv.y;
    else if (dl <= 34'sh0_7fff_ffff)    d_now = dl[31:0];
  end

  // Delay line sets the fixed evaluation latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      d_pipe   <= '0;
    end else begin
      vld_pipe[0] <= valid_in;
      d_pipe[0]   <= d_now;
      for (int i = 1; i < SDF_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        d_pipe[i]   <= d_pipe[i-1];
      end
    end
  end

  assign d         = d_pipe[SDF_LAT-1];
  assign valid_out = vld_pipe[SDF_LAT-1];
endmodule

// File: rtl/ray_march_engine.sv
// Sphere-tracing engine: one ray per ready/valid transaction, iterates
// p = ro + t*rd, t += sdf(p) until hit, far-plane miss or step budget.
//  in_valid/in_ready, ray_origin, ray_dir, obj_sel, in_tag : ray request
//  out_valid/out_ready, hit, distance, point, steps, out_tag : registered result
module ray_march_engine
  import vector_pkg::*;
#(
  parameter int MAX_STEPS = 64,
  parameter fp  HIT_EPS   = 32'sd16777,
  parameter fp  MAX_DIST  = 32'sh1000_0000,
  parameter int SDF_LAT   = 4,
  parameter int OBJ_W     = 2,
  parameter int TAG_W     = 4,
  parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [95:0]       ray_origin,
  input  logic [95:0]       ray_dir,
  input  logic [OBJ_W-1:0]  obj_sel,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              hit,
  output logic [31:0]       distance,
  output logic [95:0]       point,
  output logic [STEP_W-1:0] steps,
  output logic [TAG_W-1:0]  out_tag
);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  march_state_t       state;
  vec3                ro_q, rd_q, p_q, p_now;
  logic [OBJ_W-1:0]   sel_q;
  logic [TAG_W-1:0]   tag_q;
  fp                  t_q, d_q, t_next;
  logic [STEP_W-1:0]  step_q;
  logic [31:0]        sdf_d;
  logic               sdf_vld;

  assign p_now  = vec3_add(ro_q, vec3_scale(rd_q, t_q));
  assign t_next = fp_add_sat(t_q, d_q);

  sdf_scene #(.SDF_LAT(SDF_LAT), .OBJ_W(OBJ_W)) u_sdf (
    .clk      (clk),
    .rst      (rst),
    .p        (p_now),
    .obj_sel  (sel_q),
    .valid_in (state == S_EVAL),
    .d        (sdf_d),
    .valid_out(sdf_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      hit       <= 1'b0;
      distance  <= '0;
      point     <= '0;
      steps     <= '0;
      out_tag   <= '0;
      ro_q      <= '0;
      rd_q      <= '0;
      p_q       <= '0;
      sel_q     <= '0;
      tag_q     <= '0;
      t_q       <= '0;
      d_q       <= '0;
      step_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          ro_q     <= ray_origin;
          rd_q     <= ray_dir;
          sel_q    <= obj_sel;
          tag_q    <= in_tag;
          t_q      <= '0;
          step_q   <= '0;
          in_ready <= 1'b0;
          state    <= S_EVAL;
        end
        S_EVAL: begin
          p_q   <= p_now;
          state <= S_WAIT;
        end
        S_WAIT: if (sdf_vld) begin
          d_q    <= sdf_d;
          step_q <= step_q + STEP_W'(1);
          state  <= S_CHECK;
        end
        S_CHECK: begin
          // Negative d (inside the surface) also counts as a hit.
          if (d_q < HIT_EPS || t_next > MAX_DIST || step_q == STEP_LIMIT) begin
            out_valid <= 1'b1;
            hit       <= (d_q < HIT_EPS);
            distance  <= (d_q < HIT_EPS) ? t_q : t_next;
            point     <= p_q;
            steps     <= step_q;
            out_tag   <= tag_q;
            state     <= S_DONE;
          end else begin
            t_q   <= t_next;
            state <= S_EVAL;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ray_march_engine.sv
module tb_ray_march_engine;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in2_valid;
  logic [95:0] ray_origin, ray_dir;
  logic [1:0]  obj_sel;
  logic [3:0]  in_tag;
  logic        in_ready, out_valid, hit;
  logic [31:0] distance;
  logic [95:0] point;
  logic [6:0]  steps;
  logic [3:0]  out_tag;
  logic        in2_ready, out2_valid, hit2;
  logic [31:0] dist2;
  logic [95:0] point2;
  logic [1:0]  steps2;
  logic [3:0]  tag2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ray_march_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir), .obj_sel(obj_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .hit(hit), .distance(distance),
    .point(point), .steps(steps), .out_tag(out_tag)
  );

  ray_march_engine #(.MAX_STEPS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir), .obj_sel(obj_sel), .in_tag(in_tag),
    .out_valid(out2_valid), .out_ready(out_ready), .hit(hit2), .distance(dist2),
    .point(point2), .steps(steps2), .out_tag(tag2)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: real-number rules on integers --------
  function automatic longint sat32(longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint mmul(longint a, longint b);
    return sat32((a * b) >>> 24);
  endfunction

  function automatic longint madd(longint a, longint b);
    return sat32(a + b);
  endfunction

  function automatic longint msqrt(logic [127:0] v);
    real rv;
    logic [127:0] rr;
    rv = real'(v[63:32]) * 4294967296.0 + real'(v[31:0]);
    rr = 128'(longint'($floor($sqrt(rv))));
    while (rr * rr > v) rr--;
    while ((rr + 1) * (rr + 1) <= v) rr++;
    return longint'(rr);
  endfunction

  function automatic longint msdf(longint x, longint y, longint z, int sel);
    logic [127:0] sq;
    if (sel == 1) return y;
    sq = 128'(x * x) + 128'(y * y) + 128'(z * z);
    return sat32(msqrt(sq) - 64'sd16777216);
  endfunction

  task automatic model(input logic [95:0] ro, input logic [95:0] rd, input int sel,
                       input int maxs, output logic mh, output logic [31:0] md,
                       output logic [95:0] mp, output int ms);
    longint o[3], r[3], q[3];
    longint t, d, tn;
    for (int k = 0; k < 3; k++) begin
      o[k] = longint'($signed(ro[95-32*k -: 32]));
      r[k] = longint'($signed(rd[95-32*k -: 32]));
    end
    t = 0; ms = 0; mh = 1'b0; md = '0; mp = '0;
    while (ms < maxs) begin
      for (int k = 0; k < 3; k++) q[k] = madd(o[k], mmul(r[k], t));
      d  = msdf(q[0], q[1], q[2], sel);
      ms++;
      mp = {q[0][31:0], q[1][31:0], q[2][31:0]};
      if (d < 16777) begin
        mh = 1'b1; md = t[31:0];
        break;
      end
      tn = madd(t, d);
      md = tn[31:0];
      if (tn > 268435456) break;
      t = tn;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic run_ray(input logic [95:0] ro, input logic [95:0] rd, input logic [1:0] sel,
                         input logic [3:0] tag, output int lat);
    @(negedge clk);
    ray_origin = ro; ray_dir = rd; obj_sel = sel; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("timeout", out_valid, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_ray(input string nm, input logic eh, input logic [31:0] ed,
                           input logic [95:0] ep, input int es, input logic [3:0] et, input int lat);
    check({nm, "_hit"}, hit, eh);
    check({nm, "_dist"}, distance, ed);
    check({nm, "_point"}, point, ep);
    check({nm, "_steps"}, steps, es);
    check({nm, "_tag"}, out_tag, et);
    check({nm, "_lat"}, lat, es * 6 + 1);
  endtask

  function automatic logic [31:0] rnd_fix(int span);
    return 32'($urandom_range(0, 2 * span)) - 32'(span);
  endfunction

  localparam logic [31:0] ONE  = 32'h0100_0000;
  localparam logic [31:0] MONE = 32'hff00_0000;

  initial begin
    int lat, bad, ms, sel;
    logic mh;
    logic [31:0] md;
    logic [95:0] mp, snap, ro, rd;
    real a, b, c, l;

    rst = 1'b1; in_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b0;
    ray_origin = '0; ray_dir = '0; obj_sel = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_outs", {out_valid, hit, distance, point[63:0], steps, out_tag}, '0);
    check("rst_point_x", point[95:64], 0);
    rst = 1'b0;

    // 1: sphere hit
    run_ray({32'h0, 32'h0, 3 * ONE}, {32'h0, 32'h0, MONE}, 2'd0, 4'd5, lat);
    check_ray("sphere", 1'b1, 2 * ONE, {32'h0, 32'h0, ONE}, 2, 4'd5, lat);
    consume();
    check("sphere_ready_after", in_ready, 1);

    // 2: plane hit
    run_ray({32'h0, 5 * ONE, 32'h0}, {32'h0, MONE, 32'h0}, 2'd1, 4'd9, lat);
    check_ray("plane", 1'b1, 5 * ONE, 96'h0, 2, 4'd9, lat);
    consume();

    // 3: far-plane miss
    ro = {32'h0, 32'h0, 3 * ONE}; rd = {32'h0, ONE, 32'h0};
    model(ro, rd, 0, 64, mh, md, mp, ms);
    run_ray(ro, rd, 2'd0, 4'd3, lat);
    check("far_hit", hit, 0);
    check("far_steps", steps, 4);
    check("far_beyond", $signed(distance) > $signed(32'h1000_0000), 1);
    check_ray("far", mh, md, mp, ms, 4'd3, lat);
    consume();

    // 4: step budget on the MAX_STEPS=2 instance
    @(negedge clk);
    ray_origin = ro; ray_dir = rd; obj_sel = 2'd0; in_tag = 4'd7; in2_valid = 1'b1;
    @(negedge clk);
    in2_valid = 1'b0;
    lat = 1;
    while (!out2_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    model(ro, rd, 0, 2, mh, md, mp, ms);
    check("budget_valid", out2_valid, 1);
    check("budget_hit", hit2, 0);
    check("budget_steps", steps2, 2);
    check("budget_dist", dist2, md);
    check("budget_dist_range", (dist2 > 32'h0490_0000) && (dist2 < 32'h04a0_0000), 1);
    check("budget_lat", lat, 13);
    consume();

    // 5: backpressure
    run_ray({32'h0, 32'h0, 3 * ONE}, {32'h0, 32'h0, MONE}, 2'd0, 4'd2, lat);
    snap = point;
    md = distance;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (point !== snap || distance !== md || hit !== 1'b1 || steps !== 7'd2 ||
          out_tag !== 4'd2 || in_ready || !out_valid) bad++;
    end
    check("bp_hold", bad, 0);
    consume();
    check("bp_in_ready", in_ready, 1);
    check("bp_out_valid", out_valid, 0);

    // 6: reset mid-ray
    @(negedge clk);
    ray_origin = {32'h0, 32'h0, 3 * ONE}; ray_dir = {32'h0, 32'h0, MONE};
    obj_sel = 2'd0; in_tag = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ready", in_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("rstmid_no_valid", bad, 0);
    run_ray({32'h0, 5 * ONE, 32'h0}, {32'h0, MONE, 32'h0}, 2'd1, 4'd6, lat);
    check_ray("rstmid_plane", 1'b1, 5 * ONE, 96'h0, 2, 4'd6, lat);
    consume();

    // random rays against the model
    for (int i = 0; i < 40; i++) begin
      ro = {rnd_fix(4 * 16777216), rnd_fix(4 * 16777216), rnd_fix(4 * 16777216)};
      a = real'($urandom_range(0, 2000)) - 1000.0;
      b = real'($urandom_range(0, 2000)) - 1000.0;
      c = real'($urandom_range(0, 2000)) - 1000.0;
      l = $sqrt(a * a + b * b + c * c);
      if (l < 1.0) begin c = 1.0; l = 1.0; end
      rd = {32'(int'(a / l * 16777216.0)), 32'(int'(b / l * 16777216.0)),
            32'(int'(c / l * 16777216.0))};
      sel = int'($urandom_range(0, 3));
      model(ro, rd, sel, 64, mh, md, mp, ms);
      run_ray(ro, rd, 2'(sel), 4'(i), lat);
      check_ray($sformatf("rnd%0d", i), mh, md, mp, ms, 4'(i), lat);
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
